// File: rtl/cy_stream_rr_arbiter_pkg.sv
// cy_stream_rr_arbiter_pkg: shared state type and width helper for the stream round-robin arbiter
package cy_stream_rr_arbiter_pkg;
    typedef enum logic {IDLE, LOCKED} arb_state_e;
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction
endpackage

// File: rtl/cy_stream_rr_arbiter_if.sv
// cy_stream_rr_arbiter_if: N upstream requester lanes plus the merged downstream stream
interface cy_stream_rr_arbiter_if
    import cy_stream_rr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int IW = clog2_min1(N)
);
    logic [N-1:0]    i_valid;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    i_last;
    logic [N-1:0]    o_ready;
    logic            o_valid;
    logic            i_ready;
    logic [DW-1:0]   o_data;
    logic            o_last;
    logic [IW-1:0]   o_src;
    logic            o_busy;
    modport slave (
        input  i_valid, i_data, i_last, i_ready,
        output o_ready, o_valid, o_data, o_last, o_src, o_busy
    );
    modport master (
        output i_valid, i_data, i_last, i_ready,
        input  o_ready, o_valid, o_data, o_last, o_src, o_busy
    );
endinterface

// File: rtl/cy_stream_rr_arbiter_skidbuffer.sv
// cy_skidbuffer: two-entry skid buffer with registered output and full throughput
module cy_skidbuffer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);
    logic         skid_valid;
    logic [W-1:0] skid_data;
    assign s_ready = ~skid_valid;
    // Output refills from the skid entry first to keep order; a stalled output parks the incoming beat in the skid entry
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (m_ready || !m_valid) begin
            m_valid    <= skid_valid || s_valid;
            m_data     <= skid_valid ? skid_data : (s_valid ? s_data : m_data);
            skid_valid <= 1'b0;
        end else if (s_valid && !skid_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= s_data;
        end
    end
endmodule

// File: rtl/cy_stream_rr_arbiter.sv
// cy_stream_rr_arbiter: packet-locked round-robin merge of N valid/ready streams into one registered stream
module cy_stream_rr_arbiter
    import cy_stream_rr_arbiter_pkg::*;
#(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter bit LOCK = 1'b1
) (
    input logic                   i_clk,
    input logic                   i_reset_n,
    cy_stream_rr_arbiter_if.slave bus
);
    localparam int IW = clog2_min1(N);
    localparam int W  = DW + 1 + IW;
    arb_state_e    state, state_nxt;
    logic [IW-1:0] grant, grant_nxt, rr_ptr, rr_ptr_nxt;
    logic          skid_ready, beat_valid, accept, out_valid;
    logic [W-1:0]  beat, out_beat;

    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] v, input logic [IW-1:0] p);
        logic [IW-1:0] w;
        int j;
        w = p;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(p) + k) % N;
            if (v[j]) w = IW'(j);
        end
        return w;
    endfunction

    assign beat_valid  = (state == LOCKED) && bus.i_valid[grant];
    assign accept      = beat_valid && skid_ready;
    assign beat        = {bus.i_last[grant], grant, bus.i_data[int'(grant)*DW +: DW]};
    assign bus.o_ready = (state == LOCKED && skid_ready) ? (N'(1) << grant) : '0;
    assign bus.o_busy  = (state == LOCKED);
    assign bus.o_valid = out_valid;
    assign {bus.o_last, bus.o_src, bus.o_data} = out_beat;

    // Arbitrate while idle; release the grant and advance the pointer on the closing beat of a packet
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        if (state == IDLE && |bus.i_valid) begin
            state_nxt = LOCKED;
            grant_nxt = rr_pick(bus.i_valid, rr_ptr);
        end else if (accept && (bus.i_last[grant] || !LOCK)) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = (grant == IW'(N - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Arbiter state; asynchronous clear abandons any partially granted packet
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    cy_skidbuffer #(.W(W)) u_skid (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .s_valid   (beat_valid),
        .s_ready   (skid_ready),
        .s_data    (beat),
        .m_valid   (out_valid),
        .m_ready   (bus.i_ready),
        .m_data    (out_beat)
    );
endmodule

// File: tb/tb_cy_stream_rr_arbiter.sv
// tb_cy_stream_rr_arbiter: directed and randomized checks of the round-robin stream arbiter against a beat-queue model
module tb_cy_stream_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int compared   = 0;
    int mismatched = 0;
    int cyc = 0;
    always #5 clk = ~clk;

    cy_stream_rr_arbiter_if #(.N(N), .DW(DW)) bus ();
    cy_stream_rr_arbiter #(.N(N), .DW(DW), .LOCK(1'b1)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    logic [DW:0]  src_q [N][$];
    logic [N-1:0] hold = '0;
    logic [N-1:0] acc_seen = '0;
    bit rnd = 1'b0;
    int stall_left = 0;

    bit m_locked = 1'b0;
    int m_grant = 0;
    int m_ptr = 0;
    logic [DW+IW:0] m_q [$];
    int n_acc = 0;
    int n_out = 0;
    int out_src_log [$];
    int out_data_log [$];
    int out_cyc_log [$];
    int t3_src [5] = '{0, 1, 2, 3, 0};
    int t4_data [5] = '{'h11, 'hF9, 'h22, 'h33, 'h44};
    int t5_src [5] = '{0, 0, 0, 0, 3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: beats sit in a two-deep buffer between acceptance and delivery; arbitration scans from the pointer
    always @(negedge clk) begin : mon
        logic [N-1:0] exp_ready;
        int w;
        if (!rst_n) begin
            chk("reset_outputs", {bus.o_ready, bus.o_valid, bus.o_data, bus.o_last, bus.o_src, bus.o_busy}, '0);
            m_locked = 1'b0;
            m_grant  = 0;
            m_ptr    = 0;
            m_q.delete();
            acc_seen = '0;
            n_acc = 0;
            n_out = 0;
        end else begin
            exp_ready = (m_locked && m_q.size() < 2) ? (N'(1) << m_grant) : '0;
            chk("o_ready", bus.o_ready, exp_ready);
            chk("o_valid", bus.o_valid, m_q.size() > 0);
            chk("o_busy", bus.o_busy, m_locked);
            if (m_q.size() > 0) chk("beat", {bus.o_last, bus.o_src, bus.o_data}, m_q[0]);
            acc_seen = bus.o_ready & bus.i_valid;
            if (bus.o_valid && bus.i_ready) begin
                n_out++;
                out_src_log.push_back(int'(bus.o_src));
                out_data_log.push_back(int'(bus.o_data));
                out_cyc_log.push_back(cyc);
            end
            if (m_q.size() > 0 && bus.i_ready) void'(m_q.pop_front());
            if (m_locked && bus.i_valid[m_grant] && exp_ready[m_grant]) begin
                m_q.push_back({bus.i_last[m_grant], IW'(m_grant), bus.i_data[m_grant*DW +: DW]});
                n_acc++;
                if (bus.i_last[m_grant]) begin
                    m_locked = 1'b0;
                    m_ptr = (m_grant + 1) % N;
                end
            end else if (!m_locked && bus.i_valid != '0) begin
                w = -1;
                for (int k = 0; k < N && w < 0; k++) if (bus.i_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_locked = 1'b1;
                m_grant  = w;
            end
        end
    end

    task automatic step(input int n = 1);
        int len;
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc_seen[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (rnd && src_q[k].size() == 0 && $urandom_range(0, 2) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) src_q[k].push_back({b == len - 1, DW'($urandom)});
                end
                if (rnd) hold[k] = ($urandom_range(0, 3) == 0);
                bus.i_valid[k] = src_q[k].size() > 0 && !hold[k];
                bus.i_last[k] = src_q[k].size() > 0 ? src_q[k][0][DW] : 1'b0;
                bus.i_data[k*DW +: DW] = src_q[k].size() > 0 ? src_q[k][0][DW-1:0] : '0;
            end
            if (rnd) begin
                if (stall_left > 0) begin
                    stall_left--;
                    bus.i_ready = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    stall_left = $urandom_range(1, 8);
                    bus.i_ready = 1'b0;
                end else bus.i_ready = ($urandom_range(0, 4) != 0);
            end
            cyc++;
        end
    endtask

    task automatic push_beat(input int k, input logic [DW-1:0] d, input logic last);
        src_q[k].push_back({last, d});
    endtask

    task automatic clear_logs();
        out_src_log.delete();
        out_data_log.delete();
        out_cyc_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) src_q[k].delete();
        hold = '0;
        bus.i_valid = '0;
        bus.i_last = '0;
        bus.i_data = '0;
        step(2);
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        clear_logs();
    endtask

    initial begin
        bus.i_valid = '0;
        bus.i_data  = '0;
        bus.i_last  = '0;
        bus.i_ready = 1'b0;
        #1 rst_n = 1'b0;
        step(8);
        chk("rst_hold", {bus.o_ready, bus.o_valid, bus.o_data, bus.o_last, bus.o_src, bus.o_busy}, '0);
        rst_n = 1'b1;
        bus.i_ready = 1'b1;

        push_beat(2, 8'hB3, 1'b0);
        push_beat(2, 8'hE3, 1'b0);
        push_beat(2, 8'hB3, 1'b1);
        step();
        #1 chk("t2_c0_ready", bus.o_ready, 4'b0000);
        step();
        #1 chk("t2_c1_ready", bus.o_ready, 4'b0100);
        chk("t2_c1_busy", bus.o_busy, 1'b1);
        step();
        #1 chk("t2_c2_beat", {bus.o_valid, bus.o_last, bus.o_src, bus.o_data}, {1'b1, 1'b0, 2'd2, 8'hB3});
        step();
        #1 chk("t2_c3_beat", {bus.o_valid, bus.o_last, bus.o_src, bus.o_data}, {1'b1, 1'b0, 2'd2, 8'hE3});
        step();
        #1 chk("t2_c4_beat", {bus.o_valid, bus.o_last, bus.o_src, bus.o_data}, {1'b1, 1'b1, 2'd2, 8'hB3});
        chk("t2_c4_busy", bus.o_busy, 1'b0);
        chk("t2_rr_ptr", m_ptr, 3);

        do_reset();
        for (int k = 0; k < N; k++) push_beat(k, DW'(8'h30 + k), 1'b1);
        push_beat(0, 8'h40, 1'b1);
        step(12);
        chk("t3_count", out_src_log.size(), 5);
        for (int i = 0; i < 5 && i < out_src_log.size(); i++) chk($sformatf("t3_src%0d", i), out_src_log[i], t3_src[i]);
        for (int i = 1; i < out_cyc_log.size(); i++) chk($sformatf("t3_gap%0d", i), out_cyc_log[i] - out_cyc_log[i-1], 2);

        do_reset();
        for (int i = 0; i < 5; i++) push_beat(1, DW'(t4_data[i]), i == 4);
        step(4);
        bus.i_ready = 1'b0;
        step(2);
        #1 chk("t4_stall_ready", bus.o_ready, 4'b0000);
        chk("t4_stall_hold", {bus.o_valid, bus.o_data}, {1'b1, 8'hF9});
        step(3);
        bus.i_ready = 1'b1;
        step(8);
        chk("t4_count", out_data_log.size(), 5);
        for (int i = 0; i < 5 && i < out_data_log.size(); i++) chk($sformatf("t4_data%0d", i), out_data_log[i], t4_data[i]);

        do_reset();
        for (int i = 0; i < 4; i++) push_beat(0, DW'(8'hA0 + i), i == 3);
        push_beat(3, 8'hD3, 1'b1);
        step(2);
        hold[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1 chk("t5_ready", bus.o_ready, 4'b0001);
            chk("t5_ready3", bus.o_ready[3], 1'b0);
            chk("t5_busy", bus.o_busy, 1'b1);
        end
        hold[0] = 1'b0;
        step(10);
        chk("t5_count", out_src_log.size(), 5);
        for (int i = 0; i < 5 && i < out_src_log.size(); i++) chk($sformatf("t5_src%0d", i), out_src_log[i], t5_src[i]);

        do_reset();
        push_beat(2, 8'h62, 1'b1);
        step(4);
        for (int i = 0; i < 4; i++) push_beat(1, DW'(8'h51 + i), i == 3);
        step(4);
        #1 chk("t6_pre_valid", bus.o_valid, 1'b1);
        rst_n = 1'b0;
        #1 chk("t6_async_clear", {bus.o_valid, bus.o_busy, bus.o_ready}, '0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            #1 chk("t6_quiet", {bus.o_valid, bus.o_busy}, 2'b00);
        end
        push_beat(1, 8'h71, 1'b1);
        push_beat(3, 8'h73, 1'b1);
        step(8);
        chk("t6_count", out_src_log.size(), 2);
        if (out_src_log.size() == 2) begin
            chk("t6_first", out_src_log[0], 1);
            chk("t6_second", out_src_log[1], 3);
        end

        do_reset();
        rnd = 1'b1;
        step(3000);
        rnd = 1'b0;
        hold = '0;
        bus.i_ready = 1'b1;
        step(100);
        chk("rand_beats", n_out, n_acc);
        chk("rand_drained", {bus.o_valid, bus.o_busy}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
